// File: rtl/seg7_io_ctrl.sv
// ----------------------------------------------------------------------------
// seg7_io_ctrl
// Memory-mapped 8-digit seven-segment display controller on the IO bus.
// Holds two digit registers, a digit/decimal-point mask and a control
// register. Digits are time-multiplexed by a scan counter. A registered
// 16-bit readback feeds the IO read path.
//
// Optional feature macro: SEG7_BLINK_EN
//   When defined, a frame counter toggles a blink phase every BLINK_DIV
//   full scan frames. CTRL bit1 (blink_en) blanks the display during the
//   high phase. When undefined, CTRL bit1 is not stored and always reads 0.
//
// Register map (addr = bus address bits [2:1]):
//   0 DLO  : digits 3..0, digit 0 in bits [3:0]
//   1 DHI  : digits 7..4
//   2 MASK : [7:0] digit enable, [15:8] decimal-point enable
//   3 CTRL : bit0 blank_all, bit1 blink_en, [15:2] read as 0
// ----------------------------------------------------------------------------
module seg7_io_ctrl #(
    parameter int unsigned SCAN_DIV  = 50000,
    parameter int unsigned BLINK_DIV = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        segctrl,
    input  logic        iowrite,
    input  logic        ioread,
    input  logic [1:0]  addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic [7:0]  an,
    output logic [7:0]  seg
);

    // SCAN_DIV=1 still needs a one-bit counter that simply stays at zero.
    localparam int unsigned           SCAN_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SCAN_W-1:0]     SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

    localparam logic [1:0] ADDR_DLO  = 2'd0;
    localparam logic [1:0] ADDR_DHI  = 2'd1;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_CTRL = 2'd3;

    localparam logic [15:0] MASK_RESET = 16'h00FF;

    // ------------------------------------------------------------------
    // Hex nibble to active-low segments g..a
    // ------------------------------------------------------------------
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            4'hF:    s = 7'b0001110;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [15:0]       dlo_r;
    logic [15:0]       dhi_r;
    logic [15:0]       mask_r;
    logic [1:0]        ctrl_r;
    logic [SCAN_W-1:0] scan_cnt_r;
    logic [2:0]        digit_idx_r;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic        wr_en_s;
    logic        rd_en_s;
    logic        scan_wrap_s;
    logic [1:0]  ctrl_wr_s;
    logic [15:0] rd_mux_s;
    logic [31:0] digits_s;
    logic [3:0]  digit_nib_s;
    logic        blink_blank_s;
    logic        lit_s;
    logic [7:0]  an_next_s;
    logic [7:0]  seg_next_s;

    assign wr_en_s     = segctrl & iowrite;
    assign rd_en_s     = segctrl & ioread;
    assign scan_wrap_s = (scan_cnt_r == SCAN_LAST);
    assign digits_s    = {dhi_r, dlo_r};
    assign digit_nib_s = digits_s[{digit_idx_r, 2'b00} +: 4];

`ifdef SEG7_BLINK_EN
    localparam int unsigned        FRAME_W    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(BLINK_DIV - 1);

    logic [FRAME_W-1:0] frame_cnt_r;
    logic               blink_phase_r;
    logic               frame_wrap_s;

    assign frame_wrap_s  = scan_wrap_s & (digit_idx_r == 3'd7);
    assign blink_blank_s = ctrl_r[1] & blink_phase_r;
    assign ctrl_wr_s     = wdata[1:0];

    // Count completed 8-digit frames and toggle the blink phase every BLINK_DIV frames
    always_ff @(posedge clock) begin
        if (reset) begin
            frame_cnt_r   <= '0;
            blink_phase_r <= 1'b0;
        end else if (frame_wrap_s) begin
            if (frame_cnt_r == FRAME_LAST) begin
                frame_cnt_r   <= '0;
                blink_phase_r <= ~blink_phase_r;
            end else begin
                frame_cnt_r   <= frame_cnt_r + 1'b1;
            end
        end else begin
            frame_cnt_r   <= frame_cnt_r;
            blink_phase_r <= blink_phase_r;
        end
    end
`else
    // Without blink support only blank_all is kept; bit1 is forced to zero.
    assign blink_blank_s = 1'b0;
    assign ctrl_wr_s     = {1'b0, wdata[0]};
`endif

    // Bus register writes; strobes during reset are ignored
    always_ff @(posedge clock) begin
        if (reset) begin
            dlo_r  <= 16'h0000;
            dhi_r  <= 16'h0000;
            mask_r <= MASK_RESET;
            ctrl_r <= 2'b00;
        end else if (wr_en_s) begin
            case (addr)
                ADDR_DLO:  dlo_r  <= wdata;
                ADDR_DHI:  dhi_r  <= wdata;
                ADDR_MASK: mask_r <= wdata;
                ADDR_CTRL: ctrl_r <= ctrl_wr_s;
                default:   ctrl_r <= ctrl_r;
            endcase
        end else begin
            dlo_r  <= dlo_r;
            dhi_r  <= dhi_r;
            mask_r <= mask_r;
            ctrl_r <= ctrl_r;
        end
    end

    // Readback source selection from the current (pre-write) register values
    always_comb begin
        rd_mux_s = 16'h0000;
        case (addr)
            ADDR_DLO:  rd_mux_s = dlo_r;
            ADDR_DHI:  rd_mux_s = dhi_r;
            ADDR_MASK: rd_mux_s = mask_r;
            ADDR_CTRL: rd_mux_s = {14'h0000, ctrl_r};
            default:   rd_mux_s = 16'h0000;
        endcase
    end

    // Registered readback that holds its value between reads
    always_ff @(posedge clock) begin
        if (reset) begin
            rdata <= 16'h0000;
        end else if (rd_en_s) begin
            rdata <= rd_mux_s;
        end else begin
            rdata <= rdata;
        end
    end

    // Scan counter and digit index; bus traffic never disturbs them
    always_ff @(posedge clock) begin
        if (reset) begin
            scan_cnt_r  <= '0;
            digit_idx_r <= 3'd0;
        end else if (scan_wrap_s) begin
            scan_cnt_r  <= '0;
            digit_idx_r <= digit_idx_r + 3'd1;
        end else begin
            scan_cnt_r  <= scan_cnt_r + 1'b1;
            digit_idx_r <= digit_idx_r;
        end
    end

    // Next anode/segment pattern for the currently selected digit
    always_comb begin
        lit_s      = mask_r[digit_idx_r] & ~ctrl_r[0] & ~blink_blank_s;
        an_next_s  = 8'hFF;
        seg_next_s = 8'hFF;
        if (lit_s) begin
            an_next_s  = ~(8'b0000_0001 << digit_idx_r);
            seg_next_s = {~mask_r[{1'b1, digit_idx_r}], hex_to_seg(digit_nib_s)};
        end else begin
            an_next_s  = 8'hFF;
            seg_next_s = 8'hFF;
        end
    end

    // Register the display drive every cycle
    always_ff @(posedge clock) begin
        if (reset) begin
            an  <= 8'hFF;
            seg <= 8'hFF;
        end else begin
            an  <= an_next_s;
            seg <= seg_next_s;
        end
    end

endmodule

// File: doc/seg7_io_ctrl.md
Name: seg7_io_ctrl

Overview:
- Memory-mapped 8-digit seven-segment display controller on the IO bus, downstream of the memory/IO address decoder.
- Consumes the decoder's chip-select, ioread/iowrite strobes and 16-bit write data.
- Holds display registers, time-multiplexes digits with a scan counter, and returns registered 16-bit readback for the IO read path.

Parameters:
- SCAN_DIV, 50000, clock cycles each digit stays lit (legal range 1..2^20).
- BLINK_DIV, 64, full 8-digit scan frames per blink half-period (used only with SEG7_BLINK_EN).

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- segctrl  input  1  chip select from IO decode, active high.
- iowrite  input  1  IO write strobe.
- ioread  input  1  IO read strobe.
- addr  input  2  register select (bus address bits [2:1]).
- wdata  input  16  write data (low half of bus write data).
- rdata  output  16  registered readback.
- an  output  8  digit enables, active low; an[i] drives digit i.
- seg  output  8  segments, active low; seg[6:0]=g..a, seg[7]=dp.

Behaviour:
- Register map:
  - addr 0 DLO: nibbles = digits 3..0 (digit 0 in bits [3:0]).
  - addr 1 DHI: digits 7..4.
  - addr 2 MASK: [7:0] digit enable, [15:8] decimal-point enable.
  - addr 3 CTRL: bit0 blank_all; bit1 blink_en; bits [15:2] read 0, writes ignored.
- Reset values: DLO=0, DHI=0, MASK=16'h00FF, CTRL=0, rdata=0, an=8'hFF, seg=8'hFF, scan counter=0, digit index=0, blink phase=0.
- Write: register[addr] <= wdata on the rising edge where segctrl&iowrite=1. No effect when segctrl=0.
- Read:
  - When segctrl&ioread=1, rdata <= register[addr] on that edge; the value is valid the following cycle.
  - rdata holds its value when no read is active.
  - Read and write to the same address in the same cycle: rdata gets the pre-write value, and the write still takes effect.
- Scan counter: counts 0..SCAN_DIV-1. At SCAN_DIV-1 it wraps to 0 and the digit index increments mod 8 (7 wraps to 0).
  - SCAN_DIV=1: index advances every cycle.
  - Register writes never reset the counter or the index.
- Outputs: an/seg are registered every cycle from the current index i and the current registers, so there is 1 cycle latency from an index change or register write.
  - an = ~(8'b1<<i) if MASK[i]=1 and blank_all=0; otherwise 8'hFF.
  - seg[6:0] = hex decode of nibble i. Decode table (g..a, active low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
  - seg[7] = ~MASK[8+i].
  - When the digit is not lit, seg=8'hFF.
- Reset asserted mid-scan: all state returns to reset values on that edge. Strobes in the reset cycle are ignored.
- addr is ignored when no strobe is active. Undefined strobe combinations without segctrl are ignored.

Optional Feature:
- Macro SEG7_BLINK_EN.
- Defined:
  - A frame counter counts digit-index wraps (7->0).
  - After BLINK_DIV frames, blink phase toggles and the counter clears.
  - While blink_en=1 and phase=1, the display is blanked (an=8'hFF, seg=8'hFF). CTRL bit1 reads back as written.
- Not defined:
  - No frame or blink logic exists.
  - CTRL bit1 is ignored on write and reads 0.
  - Only bit0 is stored.

Test Plan:
- Reset, SCAN_DIV=4 -> an=FF, seg=FF during reset. After release, rdata=0; digit 0 lit (an=FE, seg=C0) from the 2nd cycle after release.
- Write DLO=16'h4321, DHI=16'hFEDC; observe one full frame -> digit 0 seg=F9, digit 3 seg=99, digit 7 seg=8E. Each digit is held exactly 4 cycles; index wraps 7->0.
- Write MASK=16'h0105 -> only digits 0 and 2 have an low. Digit 0 seg[7]=0. All other slots show an=FF, seg=FF.
- Same-cycle write+read, addr 0, with DLO=1234 and wdata=ABCD -> next cycle rdata=1234. A following read returns ABCD.
- Write CTRL=1 -> an=FF for a full frame. Read CTRL -> 0001. Write CTRL=0 -> scanning resumes without an index jump.
- With SEG7_BLINK_EN, BLINK_DIV=2, CTRL=2 -> display alternates 2 lit frames / 2 blank frames. Without the macro: CTRL reads 0000 and there is no blanking.
